imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer in front of the 2048x32 asynchronous-read instruction ROM.
//  Owns the fetch PC and converts it to the ROM word index.
//  Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
//  Handles branch/jump redirects, with flush. Flags out-of-window or misaligned fetch as a fault.
// PARAMETERS
//  ADDR_W    11            ROM word-address width (depth 2**ADDR_W)
//  RESET_PC  32'h0040_0000 byte address of ROM word 0; PC loaded on reset
//  DEPTH     2             fetch-FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       synchronous reset, active-high
//  imem_addr       out  ADDR_W  ROM word index; instruction returns in the same cycle
//  imem_inst       in   32      ROM read data, combinational from imem_addr
//  redirect_valid  in   1       branch/jump taken this cycle
//  redirect_pc     in   32      target byte address
//  out_valid       out  1       FIFO head valid
//  out_ready       in   1       decode accepts head this cycle
//  out_inst        out  32      head instruction
//  out_pc          out  32      head instruction byte address
//  fault           out  1       fetch halted; held until redirect or reset
//  fault_cause     out  2       2'b01 misaligned, 2'b10 outside ROM window, 2'b00 none
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - fetch_pc <= RESET_PC; FIFO count <= 0; state <= RUN.
//   - out_valid=0, fault=0, fault_cause=0.
//   - out_inst/out_pc = 0 while empty.
//   - rst dominates every other input, including mid-redirect.
//  Address:
//   - off = fetch_pc - RESET_PC; imem_addr = off[ADDR_W+1:2].
//   - In window iff off < 4*2**ADDR_W (unsigned) and off[1:0]==0.
//  Enqueue:
//   - Condition: state RUN, in window, and (count<DEPTH or deq this cycle), and no redirect.
//   - Action: push {fetch_pc, imem_inst}; fetch_pc <= fetch_pc+4 (32-bit wrap).
//   - Latency: first out_valid=1 one cycle after rst deasserts.
//   - Steady state: 1 instruction per cycle with out_ready held high.
//  Dequeue:
//   - deq = out_valid & out_ready; pops head.
//   - out_valid = (count!=0); head data is registered and stable while out_ready=0.
//  Full: with count==DEPTH and no deq, fetch_pc holds and no push occurs.
//  Simultaneous deq and push when full: both occur; count is unchanged.
//  Redirect (highest priority after rst):
//   - A deq in the same cycle is honoured (decode consumed the head).
//   - All remaining entries are flushed (count <= 0).
//   - The word fetched this cycle is discarded; fetch_pc <= redirect_pc.
//   - out_valid=0 the next cycle; target instruction has out_valid=1 two cycles after redirect.
//  State machine:
//   - RUN -> FAULT when the window check fails at fetch time. Causes:
//     - fetch_pc[1:0]!=0 -> fault_cause 01;
//     - otherwise out of range -> fault_cause 10.
//   - FAULT: no push; FIFO keeps draining to decode; fault=1.
//   - FAULT -> RUN on redirect_valid; fault is cleared the same edge.
//   - A misaligned redirect_pc enters FAULT on the next cycle.
//  FIFO pointers wrap modulo DEPTH; count width = $clog2(DEPTH)+1.
// STRUCTURE
//  Shared package mips31_pkg:
//   - RESET_PC, IMEM_ADDR_W.
//   - FETCH_RUN/FETCH_FAULT state encodings.
//   - FAULT_* cause codes.
//  Sub-module fetch_fifo: parameterised DEPTH x 64 synchronous FIFO.
//   - Ports: push, pop, flush, din, dout, count.
//   - Flush wins over push, and applies after pop.
//  Top holds PC register, window check, FSM and handshake glue.
// TESTING
//  1 Reset, out_ready=1, ROM word k = k:
//    - out_pc 0x00400000, 0x00400004, ... with out_inst 0, 1, 2 on consecutive cycles.
//    - First valid in cycle 1.
//  2 Backpressure: drop out_ready for 5 cycles after the first accept.
//    - count saturates at 2; imem_addr frozen; head stable.
//    - Release -> no instruction lost or duplicated.
//  3 Redirect to 0x00400100 while out_valid=1, out_ready=1:
//    - Head consumed; next cycle out_valid=0.
//    - Then out_pc=0x00400100, out_inst=0x40.
//  4 Redirect to 0x00401FFC: word 2047 delivered once, then fault=1 with cause 10.
//    - FIFO drains; redirect to 0x00400000 resumes with fault=0.
//  5 Redirect to 0x00400002 -> fault=1, cause 01; no entries pushed.
//  6 Assert rst while the FIFO is full and a redirect is active:
//    - Next cycle count=0, fault=0.
//    - fetch_pc restarts at 0x00400000.

Source files
------------

// File: rtl/mips31_pkg.sv
// Shared fetch-stage definitions: ROM geometry, reset PC, fetch FSM states and fault codes.
package mips31_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam int          IMEM_ADDR_W = 11;

    localparam logic [0:0] FETCH_RUN   = 1'b0;
    localparam logic [0:0] FETCH_FAULT = 1'b1;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Misalignment is reported in preference to a range violation.
    function automatic logic [1:0] fetch_fault_cause(input logic misaligned,
                                                     input logic out_of_range);
        if (misaligned)        return FAULT_MISALIGN;
        else if (out_of_range) return FAULT_RANGE;
        else                   return FAULT_NONE;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched {pc, inst} words; flush empties it after any same-cycle pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_eff;
    logic             push_eff;

    assign pop_eff  = pop && (count_q != '0);
    assign push_eff = push && !flush && ((count_q < CW'(DEPTH)) || pop_eff);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_eff) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_eff) - CW'(pop_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, indexes the async ROM, buffers words for decode,
// handles redirects with flush and halts on misaligned or out-of-window fetches.
module imem_fetch_ctrl
    import mips31_pkg::*;
#(
    parameter int          ADDR_W   = IMEM_ADDR_W,
    parameter logic [31:0] RESET_PC = mips31_pkg::RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic              fault,
    output logic [1:0]        fault_cause
);

    localparam int          CW           = $clog2(DEPTH) + 1;
    localparam logic [31:0] WINDOW_BYTES = 32'(64'd4 << ADDR_W);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [0:0]   state_q, state_d;
    logic [1:0]   cause_q, cause_d;

    logic [31:0]  pc_off;
    logic         misaligned;
    logic         out_of_range;
    logic         in_window;
    logic         deq;
    logic         push;
    logic [CW-1:0] fifo_count;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign pc_off       = fetch_pc_q - RESET_PC;
    assign misaligned   = (fetch_pc_q[1:0] != 2'b00);
    assign out_of_range = (pc_off >= WINDOW_BYTES);
    assign in_window    = !misaligned && !out_of_range;
    assign imem_addr    = pc_off[ADDR_W+1:2];

    assign out_valid = (fifo_count != '0);
    assign deq       = out_valid && out_ready;

    // A slot frees up when decode takes the head in the same cycle, so a full FIFO still streams.
    assign push = (state_q == FETCH_RUN) && in_window && !redirect_valid
               && ((fifo_count < CW'(DEPTH)) || deq);

    assign push_entry = '{pc: fetch_pc_q, inst: imem_inst};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        cause_d    = cause_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            state_d    = FETCH_RUN;
            cause_d    = FAULT_NONE;
        end else if (state_q == FETCH_RUN) begin
            if (!in_window) begin
                state_d = FETCH_FAULT;
                cause_d = fetch_fault_cause(misaligned, out_of_range);
            end else if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            state_q    <= FETCH_RUN;
            cause_q    <= FAULT_NONE;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            state_q    <= state_d;
            cause_q    <= cause_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (deq),
        .flush (redirect_valid),
        .din   (push_entry),
        .dout  (head_entry),
        .count (fifo_count)
    );

    assign out_inst    = out_valid ? head_entry.inst : 32'd0;
    assign out_pc      = out_valid ? head_entry.pc   : 32'd0;
    assign fault       = (state_q == FETCH_FAULT);
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic, checked every cycle against
// a queue-based model of the fetch stage.
module tb_imem_fetch_ctrl;
    import mips31_pkg::*;

    localparam int          ADDR_W = 11;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] WINDOW = 32'd8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;
    logic [1:0]  fault_cause;

    always #5 clk = ~clk;

    // ROM holds its own word index so every delivered word names the address it came from.
    assign imem_inst = {21'd0, imem_addr};

    imem_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0040_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_cause    (fault_cause)
    );

    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    logic        m_fault;
    logic [1:0]  m_cause;
    bit          check_en = 1'b0;
    int          n_compared = 0;
    int          n_mismatched = 0;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_addr;
        exp_pc   = (m_q.size() != 0) ? m_q[0][63:32] : 32'd0;
        exp_inst = (m_q.size() != 0) ? m_q[0][31:0]  : 32'd0;
        exp_addr = ((m_pc - RESET_PC) >> 2) & 32'h7FF;
        compare("out_valid",   32'(out_valid),   32'(m_q.size() != 0));
        compare("out_pc",      out_pc,           exp_pc);
        compare("out_inst",    out_inst,         exp_inst);
        compare("fault",       32'(fault),       32'(m_fault));
        compare("fault_cause", 32'(fault_cause), 32'(m_cause));
        compare("imem_addr",   32'(imem_addr),   exp_addr);
    endtask

    // Fetch-stage rules: decode takes the head first, then a redirect flushes and retargets,
    // otherwise a running fetch either faults on a bad PC or pushes if there is room.
    task automatic modelStep(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] off;
        if (r) begin
            m_pc = RESET_PC;
            m_q.delete();
            m_fault = 1'b0;
            m_cause = 2'b00;
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (rv) begin
                m_q.delete();
                m_pc = rpc;
                m_fault = 1'b0;
                m_cause = 2'b00;
            end else if (!m_fault) begin
                off = m_pc - RESET_PC;
                if (m_pc[1:0] != 2'b00) begin
                    m_fault = 1'b1;
                    m_cause = 2'b01;
                end else if (off >= WINDOW) begin
                    m_fault = 1'b1;
                    m_cause = 2'b10;
                end else if (m_q.size() < DEPTH) begin
                    m_q.push_back({m_pc, off >> 2});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        modelStep(r, rv, rpc, rdy);
        check_en = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] randomTarget();
        case ($urandom_range(0, 6))
            0, 1:    return RESET_PC + ($urandom_range(0, 2047) << 2);
            2:       return RESET_PC + WINDOW - ($urandom_range(1, 3) << 2);
            3:       return RESET_PC + ($urandom_range(0, 2047) << 2) + $urandom_range(1, 3);
            4:       return RESET_PC - 32'd4;
            5:       return RESET_PC + WINDOW + ($urandom_range(0, 3) << 2);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        out_ready = 1'b1;

        // Reset, then stream with decode always ready.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0040_0100, 1'b1);
        compare("lit_reset_valid", 32'(out_valid), 32'd0);
        compare("lit_reset_pc",    out_pc,         32'd0);
        compare("lit_reset_addr",  32'(imem_addr), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_first_valid", 32'(out_valid), 32'd1);
        compare("lit_first_pc",    out_pc,         32'h0040_0000);
        compare("lit_first_inst",  out_inst,       32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_second_pc",   out_pc,         32'h0040_0004);
        compare("lit_second_inst", out_inst,       32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_third_inst",  out_inst,       32'd2);

        // Backpressure: FIFO fills and the fetch address freezes.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        compare("lit_bp_head_pc", out_pc,         32'h0040_0008);
        compare("lit_bp_addr",    32'(imem_addr), 32'd4);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_bp_release_inst", out_inst, 32'd3);

        // Redirect while the head is being consumed.
        applyStimulus(1'b0, 1'b1, 32'h0040_0100, 1'b1);
        compare("lit_redir_bubble", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_redir_pc",   out_pc,   32'h0040_0100);
        compare("lit_redir_inst", out_inst, 32'h40);

        // Last ROM word, then fall off the end of the window.
        applyStimulus(1'b0, 1'b1, 32'h0040_1FFC, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        compare("lit_last_inst", out_inst, 32'h7FF);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        compare("lit_range_fault", 32'(fault),       32'd1);
        compare("lit_range_cause", 32'(fault_cause), 32'd2);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_range_drained", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0040_0000, 1'b1);
        compare("lit_resume_fault", 32'(fault), 32'd0);

        // Misaligned redirect target.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0040_0002, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_mis_fault", 32'(fault),       32'd1);
        compare("lit_mis_cause", 32'(fault_cause), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_mis_nopush", 32'(out_valid), 32'd0);

        // Reset lands on a full FIFO with a redirect in flight.
        applyStimulus(1'b0, 1'b1, 32'h0040_0000, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0040_0100, 1'b0);
        compare("lit_rst_valid", 32'(out_valid), 32'd0);
        compare("lit_rst_fault", 32'(fault),     32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        compare("lit_rst_restart_pc", out_pc, 32'h0040_0000);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                          randomTarget(), $urandom_range(0, 3) != 0);
        end

        check_en = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
